axis_wr_burst_master: RTL and testbench

Stream-to-memory write engine for the kernel datapath: accepts 512-bit beats on an AXI4-Stream slave (the producer side of the user-logic write FIFO) and writes them to global memory as AXI4 write bursts. A single start pulse launches a transfer of a programmed byte count to a programmed base address. The block also tracks write responses, pulses done when every burst is acknowledged, and flags any error response.

---
 rtl/axis_wr_burst_master.sv | 171 +++++++++++++++++
 tb/tb_axis_wr_burst_master.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_wr_burst_master.sv
`timescale 1ns/1ps
// Stream-to-memory write engine: turns AXI4-Stream beats into aligned AXI4 write bursts
// of a programmed byte count, tracks write responses and reports done/error.
//
// state  | meaning
// IDLE   | waiting for ctrl_start
// RUN    | issuing AW bursts, forwarding W beats, collecting B responses
// DONE   | single cycle with ctrl_done high
module axis_wr_burst_master #(
   parameter int C_M_AXI_ADDR_WIDTH = 64,
   parameter int C_M_AXI_DATA_WIDTH = 512,
   parameter int C_XFER_SIZE_WIDTH  = 32,
   parameter int C_BURST_LEN        = 64,
   parameter int C_MAX_OUTSTANDING  = 16
) (
   input  logic                              aclk,
   input  logic                              areset_n,
   input  logic                              ctrl_start,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]     ctrl_addr_offset,
   input  logic [C_XFER_SIZE_WIDTH-1:0]      ctrl_xfer_size_in_bytes,
   output logic                              ctrl_done,
   output logic                              ctrl_busy,
   output logic                              ctrl_err,
   input  logic                              s_axis_tvalid,
   output logic                              s_axis_tready,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     s_axis_tdata,
   output logic                              m_axi_awvalid,
   input  logic                              m_axi_awready,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
   output logic [7:0]                        m_axi_awlen,
   output logic                              m_axi_wvalid,
   input  logic                              m_axi_wready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
   output logic                              m_axi_wlast,
   input  logic                              m_axi_bvalid,
   output logic                              m_axi_bready,
   input  logic [1:0]                        m_axi_bresp
);

   localparam int AW         = C_M_AXI_ADDR_WIDTH;
   localparam int XW         = C_XFER_SIZE_WIDTH;
   localparam int BYTES      = C_M_AXI_DATA_WIDTH / 8;
   localparam int BYTE_SHIFT = $clog2(BYTES);
   localparam int BL_SHIFT   = $clog2(C_BURST_LEN);
   localparam int LW         = BL_SHIFT + 1;
   localparam int OW         = $clog2(C_MAX_OUTSTANDING + 1);

   localparam logic [AW-1:0] BURST_BYTES = AW'(C_BURST_LEN * BYTES);
   localparam logic [LW-1:0] BL_FULL     = LW'(C_BURST_LEN);
   localparam logic [OW-1:0] MAX_OUT     = OW'(C_MAX_OUTSTANDING);
   localparam logic [7:0]    FULL_AWLEN  = 8'(C_BURST_LEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t         state, state_nxt;
   logic [XW-1:0]  beats_calc, bursts_calc, n_bursts;
   logic [LW-1:0]  last_calc, last_len;
   logic [XW-1:0]  aw_cnt, aw_cnt_nxt;
   logic [XW-1:0]  w_burst, w_burst_nxt;
   logic [XW-1:0]  b_cnt, b_cnt_nxt;
   logic [LW-1:0]  w_beat, w_len;
   logic [OW-1:0]  outstanding, outstanding_nxt;
   logic           aw_hs, w_hs, b_hs;
   logic           start_ok, w_allowed, all_done;

   // Transfer geometry from the requested byte count: beats, bursts, last-burst length
   assign beats_calc  = (ctrl_xfer_size_in_bytes >> BYTE_SHIFT)
                      + XW'(|ctrl_xfer_size_in_bytes[BYTE_SHIFT-1:0]);
   assign bursts_calc = (beats_calc >> BL_SHIFT) + XW'(|beats_calc[BL_SHIFT-1:0]);
   assign last_calc   = (beats_calc[BL_SHIFT-1:0] == '0) ? BL_FULL
                                                          : {1'b0, beats_calc[BL_SHIFT-1:0]};

   assign aw_hs = m_axi_awvalid & m_axi_awready;
   assign w_hs  = m_axi_wvalid & m_axi_wready;
   assign b_hs  = (state == S_RUN) & m_axi_bvalid;

   assign aw_cnt_nxt  = aw_cnt + XW'(aw_hs);
   assign w_burst_nxt = w_burst + XW'(w_hs & m_axi_wlast);
   assign b_cnt_nxt   = b_cnt + XW'(b_hs);

   always_comb begin
      outstanding_nxt = outstanding;
      if (aw_hs && !b_hs)
         outstanding_nxt = outstanding + OW'(1);
      else if (!aw_hs && b_hs && outstanding != '0)
         outstanding_nxt = outstanding - OW'(1);
   end

   // Looking at next-cycle counts lets done follow the final handshake by one cycle
   assign all_done = (b_cnt_nxt == n_bursts) && (w_burst_nxt == n_bursts);

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (ctrl_start) state_nxt = S_RUN;
         S_RUN:   if (all_done)   state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      start_ok  = (state == S_IDLE) & ctrl_start;
      ctrl_done = (state == S_DONE);
      ctrl_busy = (state != S_IDLE);
      w_allowed = (state == S_RUN) && (w_burst < aw_cnt);
   end

   assign w_len         = (w_burst == n_bursts - XW'(1)) ? last_len : BL_FULL;
   assign m_axi_wlast   = w_allowed & (w_beat == w_len - LW'(1));
   assign m_axi_wvalid  = s_axis_tvalid & w_allowed;
   assign s_axis_tready = m_axi_wready & w_allowed;
   assign m_axi_wdata   = s_axis_tdata;
   assign m_axi_wstrb   = '1;
   assign m_axi_bready  = 1'b1;

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         n_bursts      <= '0;
         last_len      <= '0;
         aw_cnt        <= '0;
         w_burst       <= '0;
         w_beat        <= '0;
         b_cnt         <= '0;
         outstanding   <= '0;
         ctrl_err      <= 1'b0;
         m_axi_awvalid <= 1'b0;
         m_axi_awaddr  <= '0;
         m_axi_awlen   <= '0;
      end else if (start_ok) begin
         n_bursts      <= bursts_calc;
         last_len      <= last_calc;
         aw_cnt        <= '0;
         w_burst       <= '0;
         w_beat        <= '0;
         b_cnt         <= '0;
         outstanding   <= '0;
         ctrl_err      <= 1'b0;
         m_axi_awaddr  <= ctrl_addr_offset;
         m_axi_awlen   <= (bursts_calc == XW'(1)) ? 8'(last_calc - LW'(1)) : FULL_AWLEN;
         m_axi_awvalid <= (bursts_calc != '0);
      end else if (state == S_RUN) begin
         aw_cnt      <= aw_cnt_nxt;
         w_burst     <= w_burst_nxt;
         b_cnt       <= b_cnt_nxt;
         outstanding <= outstanding_nxt;
         if (w_hs)
            w_beat <= m_axi_wlast ? '0 : w_beat + LW'(1);
         if (b_hs && m_axi_bresp != 2'b00)
            ctrl_err <= 1'b1;
         // Address/length advance only on acceptance, so they stay stable while stalled
         if (aw_hs) begin
            m_axi_awaddr <= m_axi_awaddr + BURST_BYTES;
            m_axi_awlen  <= (aw_cnt_nxt == n_bursts - XW'(1)) ? 8'(last_len - LW'(1))
                                                              : FULL_AWLEN;
         end
         m_axi_awvalid <= (aw_cnt_nxt < n_bursts) && (outstanding_nxt < MAX_OUT);
      end else begin
         m_axi_awvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axis_wr_burst_master.sv
`timescale 1ns/1ps
// Directed bench for axis_wr_burst_master: a transfer-level model predicts every output
// cycle by cycle; a few hand-computed values pin the model itself.
module tb_axis_wr_burst_master;

   localparam int AW   = 64;
   localparam int DW   = 512;
   localparam int XW   = 32;
   localparam int BL   = 64;
   localparam int MAXO = 16;
   localparam int BB   = BL * DW / 8;

   logic            aclk = 1'b0;
   logic            areset_n = 1'b0;
   logic            ctrl_start = 1'b0;
   logic [AW-1:0]   ctrl_addr_offset = '0;
   logic [XW-1:0]   ctrl_xfer_size_in_bytes = '0;
   logic            ctrl_done, ctrl_busy, ctrl_err;
   logic            s_axis_tvalid = 1'b0;
   logic            s_axis_tready;
   logic [DW-1:0]   s_axis_tdata = '0;
   logic            m_axi_awvalid;
   logic            m_axi_awready = 1'b1;
   logic [AW-1:0]   m_axi_awaddr;
   logic [7:0]      m_axi_awlen;
   logic            m_axi_wvalid;
   logic            m_axi_wready = 1'b1;
   logic [DW-1:0]   m_axi_wdata;
   logic [DW/8-1:0] m_axi_wstrb;
   logic            m_axi_wlast;
   logic            m_axi_bvalid = 1'b0;
   logic            m_axi_bready;
   logic [1:0]      m_axi_bresp = 2'b00;

   always #5 aclk = ~aclk;

   axis_wr_burst_master #(
      .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW), .C_XFER_SIZE_WIDTH(XW),
      .C_BURST_LEN(BL), .C_MAX_OUTSTANDING(MAXO)
   ) dut (
      .aclk(aclk), .areset_n(areset_n),
      .ctrl_start(ctrl_start), .ctrl_addr_offset(ctrl_addr_offset),
      .ctrl_xfer_size_in_bytes(ctrl_xfer_size_in_bytes),
      .ctrl_done(ctrl_done), .ctrl_busy(ctrl_busy), .ctrl_err(ctrl_err),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
      .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic chk_wide(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual[63:0]=%0h expected[63:0]=%0h (t=%0t)",
                    name, act[63:0], exp[63:0], $time);
   endtask

   function automatic logic [DW-1:0] pat(input int i);
      logic [31:0] w;
      w = 32'(i) ^ 32'hA5A5_0000;
      return {16{w}};
   endfunction

   // transfer-level model state (written only by the monitor)
   int          phase = 0;
   int          m_n, m_k, m_l;
   logic [63:0] m_base;
   int          m_aw, m_out, m_b, m_w, m_wb, m_beat;
   bit          done_due = 0;
   bit          exp_err = 0;
   int          stream_base;
   int          cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0, last_b_cyc = 0, tot_wlast = 0;
   logic [63:0] q_addr[$];
   int          q_len[$];
   bit          f_aw = 0, f_w = 0, f_b = 0;
   bit          prev_stall = 0;
   logic [63:0] prev_addr;
   logic [7:0]  prev_len;

   // stimulus knobs
   int idx = 0;
   bit tv_rand = 0, wr_rand = 0, awr_rand = 0;
   int aw_stall = 0;
   bit b_limited = 0;
   int b_budget = 0;
   int err_idx = -1;

   always @(negedge aclk) begin
      int cur;
      cyc++;
      if (!areset_n) begin
         phase = 0; done_due = 0; exp_err = 0;
         m_aw = 0; m_out = 0; m_b = 0; m_w = 0; m_wb = 0; m_beat = 0; m_k = 0;
         f_aw = 0; f_w = 0; f_b = 0; prev_stall = 0;
      end else begin
         f_aw = m_axi_awvalid && m_axi_awready;
         f_w  = m_axi_wvalid && m_axi_wready;
         f_b  = m_axi_bvalid && m_axi_bready;

         chk("done", ctrl_done, done_due);
         chk("busy", ctrl_busy, phase == 1);
         chk("err", ctrl_err, exp_err);
         chk("bready", m_axi_bready, 1);
         chk("awvalid", m_axi_awvalid, phase == 1 && m_aw < m_k && m_out < MAXO);
         chk("wvalid", m_axi_wvalid, s_axis_tvalid && phase == 1 && m_wb < m_aw);
         chk("tready", s_axis_tready, m_axi_wready && phase == 1 && m_wb < m_aw);
         if (m_axi_awvalid) begin
            chk("awaddr", m_axi_awaddr, m_base + 64'(m_aw) * 64'(BB));
            chk("awlen", 64'(m_axi_awlen), (m_aw == m_k - 1) ? 64'(m_l - 1) : 64'(BL - 1));
         end
         if (prev_stall) begin
            chk("awaddr_stable", m_axi_awaddr, prev_addr);
            chk("awlen_stable", 64'(m_axi_awlen), 64'(prev_len));
         end
         if (m_axi_wvalid) begin
            cur = (m_wb == m_k - 1) ? m_l : BL;
            chk("wlast", m_axi_wlast, m_beat == cur - 1);
            chk_wide("wdata_pass", m_axi_wdata, s_axis_tdata);
         end
         if (f_w) begin
            chk_wide("wdata_order", m_axi_wdata, pat(stream_base + m_w));
            chk("w_overrun", m_w < m_n, 1);
         end

         if (phase == 1) begin
            if (done_due) begin
               phase = 0; done_due = 0; done_cnt++; done_cyc = cyc;
            end else begin
               if (f_aw) begin
                  q_addr.push_back(m_axi_awaddr);
                  q_len.push_back(int'(m_axi_awlen));
                  m_aw++; m_out++;
               end
               if (f_b) begin
                  m_b++; m_out--; last_b_cyc = cyc;
                  if (m_axi_bresp != 2'b00) exp_err = 1;
               end
               if (f_w) begin
                  cur = (m_wb == m_k - 1) ? m_l : BL;
                  m_w++;
                  if (m_axi_wlast) tot_wlast++;
                  if (m_beat == cur - 1) begin m_beat = 0; m_wb++; end
                  else m_beat++;
               end
               done_due = (m_b == m_k) && (m_wb == m_k);
            end
         end else if (ctrl_start) begin
            phase  = 1;
            m_n    = (int'(ctrl_xfer_size_in_bytes) + DW/8 - 1) / (DW/8);
            m_k    = (m_n + BL - 1) / BL;
            m_l    = m_n - (m_k - 1) * BL;
            m_base = ctrl_addr_offset;
            m_aw = 0; m_out = 0; m_b = 0; m_w = 0; m_wb = 0; m_beat = 0;
            exp_err = 0; stream_base = idx; start_cyc = cyc; tot_wlast = 0;
            q_addr.delete(); q_len.delete();
         end
         prev_stall = m_axi_awvalid && !m_axi_awready;
         prev_addr  = m_axi_awaddr;
         prev_len   = m_axi_awlen;
      end
   end

   // stream source and memory responder; react to handshakes seen by the monitor
   initial begin
      forever begin
         @(posedge aclk); #1;
         if (f_w) idx++;
         if (b_limited && f_b && b_budget > 0) b_budget--;
         s_axis_tvalid = tv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         s_axis_tdata  = pat(idx);
         if (aw_stall > 0) begin
            m_axi_awready = 1'b0;
            aw_stall--;
         end else begin
            m_axi_awready = awr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         m_axi_wready = wr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         m_axi_bvalid = areset_n && (!b_limited || b_budget > 0)
                        && (((m_aw < m_wb) ? m_aw : m_wb) > m_b);
         m_axi_bresp  = (m_b == err_idx) ? 2'b10 : 2'b00;
      end
   end

   task automatic start_xfer(input logic [63:0] base, input int size);
      @(posedge aclk); #1;
      ctrl_addr_offset        = base;
      ctrl_xfer_size_in_bytes = 32'(size);
      ctrl_start              = 1'b1;
      @(posedge aclk); #1;
      ctrl_start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int d0;
      int n;
      d0 = done_cnt;
      n  = 0;
      while (done_cnt == d0 && n < budget) begin
         @(negedge aclk); #1;
         n++;
      end
      chk(name, done_cnt != d0, 1);
   endtask

   initial begin
      repeat (3) @(posedge aclk);
      #2;
      chk("rst_done", ctrl_done, 0);
      chk("rst_busy", ctrl_busy, 0);
      chk("rst_err", ctrl_err, 0);
      chk("rst_awvalid", m_axi_awvalid, 0);
      chk("rst_wvalid", m_axi_wvalid, 0);
      chk("rst_wlast", m_axi_wlast, 0);
      chk("rst_awaddr", m_axi_awaddr, 0);
      chk("rst_awlen", 64'(m_axi_awlen), 0);
      chk("rst_bready", m_axi_bready, 1);
      chk("rst_tready", s_axis_tready, 0);
      chk("wstrb", m_axi_wstrb, 64'hFFFF_FFFF_FFFF_FFFF);
      areset_n = 1'b1;
      repeat (2) @(posedge aclk);

      // single full burst
      start_xfer(64'h0, 4096);
      chk("first_awvalid", m_axi_awvalid, 1);
      wait_done("t1_done_timeout", 2000);
      chk("t1_aw_count", q_addr.size(), 1);
      chk("t1_awaddr0", q_addr[0], 64'h0);
      chk("t1_awlen0", 64'(q_len[0]), 63);
      chk("t1_beats", m_w, 64);
      chk("t1_wlast_count", tot_wlast, 1);
      chk("t1_err", ctrl_err, 0);
      chk("t1_done_count", done_cnt, 1);

      // 129 beats -> 64 + 64 + 1
      start_xfer(64'h0, 8256);
      wait_done("t2_done_timeout", 2000);
      chk("t2_aw_count", q_addr.size(), 3);
      chk("t2_awaddr0", q_addr[0], 64'h0);
      chk("t2_awaddr1", q_addr[1], 64'h1000);
      chk("t2_awaddr2", q_addr[2], 64'h2000);
      chk("t2_awlen0", 64'(q_len[0]), 63);
      chk("t2_awlen1", 64'(q_len[1]), 63);
      chk("t2_awlen2", 64'(q_len[2]), 0);
      chk("t2_beats", m_w, 129);
      chk("t2_done_after_b", done_cyc - last_b_cyc, 1);

      // AW stalled 20 cycles, random W/stream handshakes; 8832 B = 138 beats
      aw_stall = 20; tv_rand = 1; wr_rand = 1; awr_rand = 1;
      start_xfer(64'h10000, 8832);
      wait_done("t3_done_timeout", 4000);
      chk("t3_aw_count", q_addr.size(), 3);
      chk("t3_awaddr2", q_addr[2], 64'h12000);
      chk("t3_awlen2", 64'(q_len[2]), 9);
      chk("t3_beats", m_w, 138);
      tv_rand = 0; wr_rand = 0; awr_rand = 0;

      // responses withheld: AW issue stops at the outstanding limit
      b_limited = 1; b_budget = 0;
      start_xfer(64'h0, 20 * 4096);
      repeat (1400) @(negedge aclk);
      #1;
      chk("t4_aw_capped", q_addr.size(), 16);
      chk("t4_awvalid_low", m_axi_awvalid, 0);
      b_budget = 1;
      repeat (10) @(negedge aclk);
      #1;
      chk("t4_aw_after_one_b", q_addr.size(), 17);
      b_limited = 0;
      wait_done("t4_done_timeout", 3000);
      chk("t4_beats", m_w, 1280);
      chk("t4_aw_total", q_addr.size(), 20);

      // error response on the second of three bursts
      err_idx = 1;
      start_xfer(64'h0, 8256);
      wait_done("t5_done_timeout", 2000);
      chk("t5_err_at_done", ctrl_err, 1);
      repeat (5) @(negedge aclk);
      #1;
      chk("t5_err_sticky", ctrl_err, 1);
      err_idx = -1;

      // zero-length transfer clears the error and finishes two cycles after start
      start_xfer(64'h0, 0);
      chk("t6_err_cleared", ctrl_err, 0);
      wait_done("t6_done_timeout", 20);
      chk("t6_done_latency", done_cyc - start_cyc, 2);
      chk("t6_aw_count", q_addr.size(), 0);
      chk("t6_beats", m_w, 0);

      // asynchronous reset in the middle of a transfer
      start_xfer(64'h0, 8192);
      repeat (30) @(posedge aclk);
      #3;
      areset_n = 1'b0;
      #1;
      chk("mid_rst_awvalid", m_axi_awvalid, 0);
      chk("mid_rst_wvalid", m_axi_wvalid, 0);
      chk("mid_rst_tready", s_axis_tready, 0);
      chk("mid_rst_wlast", m_axi_wlast, 0);
      chk("mid_rst_busy", ctrl_busy, 0);
      chk("mid_rst_done", ctrl_done, 0);
      chk("mid_rst_awaddr", m_axi_awaddr, 0);
      chk("mid_rst_awlen", 64'(m_axi_awlen), 0);
      chk("mid_rst_bready", m_axi_bready, 1);
      repeat (2) @(posedge aclk);
      #2;
      areset_n = 1'b1;
      repeat (2) @(posedge aclk);
      start_xfer(64'h20000, 4096);
      wait_done("t7_done_timeout", 2000);
      chk("t7_aw_count", q_addr.size(), 1);
      chk("t7_awaddr0", q_addr[0], 64'h20000);
      chk("t7_beats", m_w, 64);
      chk("t7_err", ctrl_err, 0);

      repeat (3) @(posedge aclk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
